// File: rtl/aes_pkg.sv
// Shared AES definitions used by the encryptor, load-side and collector blocks.
// The collector's two-state FSM type is here so checkers can bind to it by name.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;
    localparam int AES_IDX_W   = 4;

    typedef logic [AES_IDX_W-1:0] aes_idx_t;

    localparam aes_idx_t AES_LAST_IDX = aes_idx_t'(AES_BYTES - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } col_state_t;

    // Byte 0 of a block lands in the most significant byte of the 128-bit word.
    function automatic int unsigned byte_lsb(input aes_idx_t idx);
        return 8 * (AES_BYTES - 1 - int'(idx));
    endfunction

endpackage

// File: rtl/ct_fifo.sv
// Synchronous FIFO holding completed ciphertext blocks.
// A push while full is taken only when a pop happens on the same edge.
module ct_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB separates the full and empty cases when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end

    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/aes_ct_collector.sv
// Rebuilds 128-bit ciphertext blocks from the encryptor's byte stream, buffers them
// and delivers them on a valid/ready port, with block count and sticky error flags.
module aes_ct_collector
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic [AES_BLOCK_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CNT_W-1:0]       blk_count,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   clr_err,
    output logic                   busy,
    output col_state_t             dbg_state
);

    // Output handshake: a block transfers on every edge where m_valid && m_ready;
    // m_data is held while m_valid && !m_ready. There is no backpressure on the input.

    col_state_t             state_q, state_d;
    aes_idx_t               cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0]       blk_count_q, blk_count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;

    logic                   push_vld;
    logic                   frame_set;
    logic                   push_acc;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [AES_BLOCK_W-1:0] push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            asm_q       <= '0;
            blk_count_q <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            blk_count_q <= blk_count_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    asm_d[byte_lsb(cnt_q) +: 8] = in_byte;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!in_valid || cnt_q == AES_LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    asm_d[byte_lsb(cnt_q) +: 8] = in_byte;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        push_vld  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            ST_IDLE:    push_vld  = 1'b0;
            ST_COLLECT: begin
                push_vld  = in_valid && (cnt_q == AES_LAST_IDX);
                frame_set = !in_valid;
            end
            default:    frame_set = 1'b0;
        endcase
    end

    assign push_data = {asm_q[AES_BLOCK_W-1:8], in_byte};
    assign pop       = !fifo_empty && m_ready;
    assign push_acc  = push_vld && (!fifo_full || pop);

    // A new error event on the same edge as clr_err keeps the flag set.
    always_comb begin
        blk_count_d = blk_count_q;
        frame_err_d = frame_err_q;
        overflow_d  = overflow_q;
        if (push_acc) blk_count_d = blk_count_q + 1'b1;
        if (clr_err) begin
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end
        if (frame_set) frame_err_d = 1'b1;
        if (push_vld && !push_acc) overflow_d = 1'b1;
    end

    ct_fifo #(
        .WIDTH (AES_BLOCK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_acc),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (m_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign m_valid   = !fifo_empty;
    assign blk_count = blk_count_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign busy      = (cnt_q != '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_ct_collector.sv
// Directed bench for aes_ct_collector: byte bursts in, block/flag checks out.
module tb_aes_ct_collector;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [15:0]  blk_count;
    logic         frame_err;
    logic         overflow;
    logic         clr_err;
    logic         busy;
    col_state_t   dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] BLK_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_A    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] BLK_B    = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] BLK_C    = 128'h202122232425262728292a2b2c2d2e2f;
    localparam logic [127:0] BLK_OLD  = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    localparam logic [127:0] BLK_NEW  = 128'h30313233343536373839303132333435;

    always #5 clk = ~clk;

    aes_ct_collector #(.DEPTH(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .blk_count (blk_count),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clr_err   (clr_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        m_ready  = 1'b0;
        clr_err  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Sends the first n bytes of blk, one per cycle, leaving in_valid high.
    task automatic send_bytes(input logic [127:0] blk, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_byte  = blk[127-8*i -: 8];
            tick();
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // FIPS-197 C.1 ciphertext, latency of one edge after the 16th byte
        m_ready = 1'b1;
        send_bytes(BLK_FIPS, 15);
        check("t1_valid_before_last", m_valid, 0);
        check("t1_busy_mid", busy, 1);
        check("t1_state_mid", dbg_state, ST_COLLECT);
        send_bytes(BLK_FIPS << 120, 1);
        in_valid = 1'b0;
        check("t1_m_valid", m_valid, 1);
        check("t1_m_data", m_data, BLK_FIPS);
        check("t1_blk_count", blk_count, 1);
        check("t1_busy_end", busy, 0);
        tick();
        check("t1_popped", m_valid, 0);
        check("t1_no_frame_err", frame_err, 0);

        // Three back-to-back bursts into a stalled depth-2 FIFO
        do_reset();
        send_bytes(BLK_A, 16);
        send_bytes(BLK_B, 16);
        send_bytes(BLK_C, 16);
        in_valid = 1'b0;
        check("t2_overflow", overflow, 1);
        check("t2_blk_count", blk_count, 2);
        check("t2_frame_err", frame_err, 0);
        check("t2_head_a", m_data, BLK_A);
        tick();
        check("t2_head_held", m_data, BLK_A);
        m_ready = 1'b1;
        tick();
        check("t2_head_b", m_data, BLK_B);
        check("t2_valid_b", m_valid, 1);
        tick();
        check("t2_drained", m_valid, 0);
        check("t2_overflow_sticky", overflow, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t2_overflow_clr", overflow, 0);

        // Short burst then a good one
        do_reset();
        send_bytes(BLK_OLD, 7);
        check("t3_busy_partial", busy, 1);
        in_valid = 1'b0;
        tick();
        check("t3_frame_err", frame_err, 1);
        check("t3_m_valid", m_valid, 0);
        check("t3_busy_after_err", busy, 0);
        send_bytes(BLK_A, 16);
        in_valid = 1'b0;
        check("t3_data", m_data, BLK_A);
        check("t3_blk_count", blk_count, 1);
        check("t3_busy_done", busy, 0);
        check("t3_frame_err_sticky", frame_err, 1);

        // Full FIFO, 16th byte of a third block coincides with a pop
        do_reset();
        send_bytes(BLK_A, 16);
        send_bytes(BLK_B, 16);
        send_bytes(BLK_C, 15);
        m_ready = 1'b1;
        send_bytes(BLK_C << 120, 1);
        m_ready  = 1'b0;
        in_valid = 1'b0;
        check("t4_no_overflow", overflow, 0);
        check("t4_blk_count", blk_count, 3);
        check("t4_head_b", m_data, BLK_B);
        m_ready = 1'b1;
        tick();
        check("t4_head_c", m_data, BLK_C);
        check("t4_still_valid", m_valid, 1);
        tick();
        check("t4_empty", m_valid, 0);

        // Reset in the middle of a burst
        do_reset();
        m_ready = 1'b0;
        send_bytes(BLK_OLD, 9);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("t5_m_valid", m_valid, 0);
        check("t5_m_data", m_data, 0);
        check("t5_blk_count", blk_count, 0);
        check("t5_frame_err", frame_err, 0);
        check("t5_overflow", overflow, 0);
        check("t5_busy", busy, 0);
        rst = 1'b0;
        send_bytes(BLK_NEW, 16);
        in_valid = 1'b0;
        check("t5_data", m_data, BLK_NEW);
        check("t5_blk_count_new", blk_count, 1);
        m_ready = 1'b1;
        tick();
        check("t5_single_block", m_valid, 0);

        // clr_err on the same edge a short burst ends
        do_reset();
        send_bytes(BLK_A, 3);
        in_valid = 1'b0;
        clr_err  = 1'b1;
        tick();
        check("t6_err_wins", frame_err, 1);
        tick();
        clr_err = 1'b0;
        check("t6_err_cleared", frame_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
